// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JALR, PC_RSVD} pc_sel_e;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;
    localparam logic [31:0] INSTR_BYTES = 32'd4;
endpackage

// File: rtl/pc_next_gen.sv
// pc_next_gen: next-PC target selection and alignment check
module pc_next_gen
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_res,
    output logic [31:0] target,
    output logic        misaligned
);
    logic [31:0] seq;
    always_comb begin
        seq = pc + INSTR_BYTES;
        target = (pc_sel == PC_BRANCH) ? (branch_taken ? pc + imm_ext : seq) :
                 (pc_sel == PC_JALR)   ? (alu_res & ~32'h1) : seq;
        misaligned = |target[1:0];
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, fetch FSM, fault capture and retire counter
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      pc_sel,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] inst,
    output logic [24:0]     inst_imm,
    output logic            inst_valid,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [XLEN-1:0] retired
);
    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, fault_addr_q, fault_addr_d, retired_q, retired_d, target;
    logic fault_q, fault_d, misaligned, adv, trap;

    pc_next_gen u_next (
        .pc(pc_q), .pc_sel(pc_sel), .branch_taken(branch_taken), .imm_ext(imm_ext),
        .alu_res(alu_res), .target(target), .misaligned(misaligned)
    );

    always_comb begin
        adv = (state_q == RUN) && !stall;
        trap = adv && misaligned;
        state_d = (state_q == BOOT) ? RUN : trap ? FAULT : state_q;
        pc_d = (adv && !misaligned) ? target : pc_q;
        retired_d = (adv && !misaligned) ? retired_q + 1'b1 : retired_q;
        fault_d = fault_q | trap;
        fault_addr_d = trap ? target : fault_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q <= RESET_VECTOR;
            retired_q <= '0;
            fault_q <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            retired_q <= retired_d;
            fault_q <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4 = pc_q + INSTR_BYTES;
    assign inst = imem_rdata;
    assign inst_imm = imem_rdata[31:7];
    assign inst_valid = (state_q == RUN);
    assign fault = fault_q;
    assign fault_addr = fault_addr_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of the fetch stage against hand-computed values
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst, stall, branch_taken;
    logic [1:0] pc_sel;
    logic [31:0] imm_ext, alu_res, imem_rdata;
    logic [31:0] imem_addr, pc, pc_plus4, inst, fault_addr, retired;
    logic [24:0] inst_imm;
    logic inst_valid, fault;
    logic [31:0] w_addr, w_pc, w_p4, w_inst, w_faddr, w_ret;
    logic [24:0] w_imm;
    logic w_valid, w_fault;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .branch_taken(branch_taken),
        .imm_ext(imm_ext), .alu_res(alu_res), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .pc(pc), .pc_plus4(pc_plus4), .inst(inst), .inst_imm(inst_imm), .inst_valid(inst_valid),
        .fault(fault), .fault_addr(fault_addr), .retired(retired)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .branch_taken(branch_taken),
        .imm_ext(imm_ext), .alu_res(alu_res), .imem_rdata(imem_rdata), .imem_addr(w_addr),
        .pc(w_pc), .pc_plus4(w_p4), .inst(w_inst), .inst_imm(w_imm), .inst_valid(w_valid),
        .fault(w_fault), .fault_addr(w_faddr), .retired(w_ret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_core(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ret,
                               input logic e_valid, input logic e_fault);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".retired"}, retired, e_ret);
        check({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_sel = 2'b00; branch_taken = 1'b0;
        imm_ext = '0; alu_res = '0; imem_rdata = 32'h0050_0093;
        step();
        expect_core("reset", 32'h0, 32'd0, 1'b0, 1'b0);
        check("reset.faddr", fault_addr, 32'h0);
        check("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
        rst = 1'b0;
        step();
        expect_core("boot", 32'h0, 32'd0, 1'b1, 1'b0);
        check("wrap.boot_pc", w_pc, 32'hFFFF_FFFC);
        step();
        expect_core("seq1", 32'h4, 32'd1, 1'b1, 1'b0);
        check("wrap.pc", w_pc, 32'h0);
        check("wrap.fault", {31'd0, w_fault}, 32'd0);
        check("wrap.retired", w_ret, 32'd1);
        step();
        expect_core("seq2", 32'h8, 32'd2, 1'b1, 1'b0);
        check("inst_imm", {7'd0, inst_imm}, 32'h0000_A001);
        check("inst", inst, 32'h0050_0093);
        check("imem_addr", imem_addr, 32'h8);
        check("pc_plus4", pc_plus4, 32'hC);

        pc_sel = 2'b01; branch_taken = 1'b1; imm_ext = 32'h10;
        step();
        expect_core("br_fwd", 32'h18, 32'd3, 1'b1, 1'b0);
        imm_ext = 32'hFFFF_FFF8;
        step();
        expect_core("br_back", 32'h10, 32'd4, 1'b1, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_core("br_not", 32'h14, 32'd5, 1'b1, 1'b0);
        pc_sel = 2'b11;
        step();
        expect_core("rsvd", 32'h18, 32'd6, 1'b1, 1'b0);

        pc_sel = 2'b10; alu_res = 32'h101;
        step();
        expect_core("jalr", 32'h100, 32'd7, 1'b1, 1'b0);
        alu_res = 32'h102;
        step();
        expect_core("jalr_mis", 32'h100, 32'd7, 1'b0, 1'b1);
        check("fault_addr", fault_addr, 32'h102);
        pc_sel = 2'b00; alu_res = 32'h200;
        step();
        step();
        expect_core("frozen", 32'h100, 32'd7, 1'b0, 1'b1);
        check("frozen.faddr", fault_addr, 32'h102);

        rst = 1'b1;
        step();
        expect_core("rst_fault", 32'h0, 32'd0, 1'b0, 1'b0);
        check("rst_fault.faddr", fault_addr, 32'h0);
        rst = 1'b0;
        step();
        expect_core("boot2", 32'h0, 32'd0, 1'b1, 1'b0);
        step();
        expect_core("seq3", 32'h4, 32'd1, 1'b1, 1'b0);

        stall = 1'b1; pc_sel = 2'b01; branch_taken = 1'b1; imm_ext = 32'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_core("stall", 32'h4, 32'd1, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_core("release", 32'h24, 32'd2, 1'b1, 1'b0);
        pc_sel = 2'b00;
        step();
        expect_core("after_rel", 32'h28, 32'd3, 1'b1, 1'b0);

        stall = 1'b1; pc_sel = 2'b10; alu_res = 32'h102;
        step();
        expect_core("stall_mis", 32'h28, 32'd3, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        expect_core("rst_stall", 32'h0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0; pc_sel = 2'b00;
        step();
        expect_core("boot3", 32'h0, 32'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
